// File: rtl/mem_ctr_line_pkg.sv
// Shared bus-2 definitions for the line memory controller: command codes,
// controller states and default geometry/latency.
package mem_ctr_line_pkg;

  typedef enum logic [1:0] {
    C2_NOP        = 2'd0,
    C2_RESPONSE   = 2'd1,
    C2_READ_LINE  = 2'd2,
    C2_WRITE_LINE = 2'd3
  } c2_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_RECV = 3'd1,
    ST_RD_LOAD = 3'd2,
    ST_WAIT    = 3'd3,
    ST_RESP    = 3'd4,
    ST_RD_SEND = 3'd5
  } mc_state_e;

  localparam int MEM_SIZE_DEF        = 524288;
  localparam int CACHE_LINE_SIZE_DEF = 16;
  localparam int ADDR2_BUS_SIZE_DEF  = 15;
  localparam int DATA2_BUS_SIZE_DEF  = 16;
  localparam int MEM_CTR_DELAY_DEF   = 100;

endpackage

// File: rtl/mem_ctr_line_if.sv
// Bus-2 signal bundle between the cache (master) and the memory controller (slave).
interface mem_ctr_line_if
  import mem_ctr_line_pkg::*;
#(
  parameter int ADDR2_BUS_SIZE = ADDR2_BUS_SIZE_DEF,
  parameter int DATA2_BUS_SIZE = DATA2_BUS_SIZE_DEF
);

  logic [ADDR2_BUS_SIZE-1:0] A2_IN;
  logic [DATA2_BUS_SIZE-1:0] D2_IN;
  c2_e                       C2_IN;
  logic [DATA2_BUS_SIZE-1:0] D2_OUT;
  c2_e                       C2_OUT;
  logic                      D2_OE;
  logic                      C2_OE;

  modport master (
    output A2_IN, D2_IN, C2_IN,
    input  D2_OUT, C2_OUT, D2_OE, C2_OE
  );

  modport slave (
    input  A2_IN, D2_IN, C2_IN,
    output D2_OUT, C2_OUT, D2_OE, C2_OE
  );

endinterface

// File: rtl/mem_ctr_line_array.sv
// Backing RAM with one line-wide port: combinational line read, whole-line write per cycle.
// Lines beyond MEM_SIZE read as zero and ignore writes.
module mem_ctr_line_array
  import mem_ctr_line_pkg::*;
#(
  parameter int MEM_SIZE        = MEM_SIZE_DEF,
  parameter int CACHE_LINE_SIZE = CACHE_LINE_SIZE_DEF,
  parameter int ADDR2_BUS_SIZE  = ADDR2_BUS_SIZE_DEF
) (
  input  logic                         CLK,
  input  logic                         m_dump,
  input  logic [ADDR2_BUS_SIZE-1:0]    line_idx,
  input  logic                         wr_en,
  input  logic [CACHE_LINE_SIZE*8-1:0] wr_line,
  output logic [CACHE_LINE_SIZE*8-1:0] rd_line
);

  localparam int LINE_W = CACHE_LINE_SIZE * 8;
  localparam int LINES  = MEM_SIZE / CACHE_LINE_SIZE;
  localparam int IDX_W  = (LINES > 1) ? $clog2(LINES) : 1;

  if (IDX_W > ADDR2_BUS_SIZE) begin : g_bad_idx
    $error("mem_ctr_line_array: RAM has more lines than A2 can address");
  end

  // Stored line-wide since every access moves a full line.
  logic [LINE_W-1:0] mem_r [LINES];
  logic              in_range_s;
  logic              unused_dump_s;

  // The dump strobe is a simulation hook; the synthesizable array only terminates it.
  assign unused_dump_s = m_dump;
  assign in_range_s    = (32'(line_idx) < 32'(LINES));
  assign rd_line       = in_range_s ? mem_r[line_idx[IDX_W-1:0]] : {LINE_W{1'b0}};

  // Line write port; RAM contents are deliberately not reset.
  always_ff @(posedge CLK) begin
    if (wr_en && in_range_s) begin
      mem_r[line_idx[IDX_W-1:0]] <= wr_line;
    end
  end

endmodule

// File: rtl/mem_ctr_line.sv
// Bus-2 line memory controller: multi-beat line write/read bursts answered a fixed
// MEM_CTR_DELAY cycles after the command, with explicit bus output enables.
module mem_ctr_line
  import mem_ctr_line_pkg::*;
#(
  parameter int MEM_SIZE        = MEM_SIZE_DEF,
  parameter int CACHE_LINE_SIZE = CACHE_LINE_SIZE_DEF,
  parameter int ADDR2_BUS_SIZE  = ADDR2_BUS_SIZE_DEF,
  parameter int DATA2_BUS_SIZE  = DATA2_BUS_SIZE_DEF,
  parameter int MEM_CTR_DELAY   = MEM_CTR_DELAY_DEF
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          M_DUMP,
  mem_ctr_line_if.slave bus
);

  localparam int LINE_W = CACHE_LINE_SIZE * 8;
  localparam int BEATS  = LINE_W / DATA2_BUS_SIZE;
  localparam int CNT_W  = $clog2(MEM_CTR_DELAY + 1);
  localparam int BEAT_W = $clog2(BEATS + 1);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_RESP   = CNT_W'(MEM_CTR_DELAY - 1);
  localparam logic [BEAT_W-1:0] BEAT_ZERO  = BEAT_W'(0);
  localparam logic [BEAT_W-1:0] BEAT_ONE   = BEAT_W'(1);
  localparam logic [BEAT_W-1:0] BEAT_LAST  = BEAT_W'(BEATS - 1);
  localparam logic [BEAT_W-1:0] BEAT_END   = BEAT_W'(BEATS);
  localparam bit                SINGLE_BEAT = (BEATS == 32'sd1);

  if ((DATA2_BUS_SIZE % 8 != 0) || (LINE_W % DATA2_BUS_SIZE != 0)) begin : g_bad_width
    $error("mem_ctr_line: DATA2_BUS_SIZE must be a byte multiple dividing the line");
  end
  if (MEM_SIZE % CACHE_LINE_SIZE != 0) begin : g_bad_size
    $error("mem_ctr_line: MEM_SIZE must be a multiple of CACHE_LINE_SIZE");
  end
  if (MEM_CTR_DELAY < BEATS + 1) begin : g_bad_delay
    $error("mem_ctr_line: MEM_CTR_DELAY must be at least BEATS+1");
  end

  // Beat k occupies line bits [k*DATA2 +: DATA2], lowest byte first.
  function automatic logic [DATA2_BUS_SIZE-1:0] get_beat(input logic [LINE_W-1:0] line,
                                                         input logic [BEAT_W-1:0] k);
    logic [DATA2_BUS_SIZE-1:0] r;
    r = {DATA2_BUS_SIZE{1'b0}};
    for (int i = 0; i < BEATS; i++) begin
      if (k == BEAT_W'(i)) r = line[i*DATA2_BUS_SIZE +: DATA2_BUS_SIZE];
    end
    return r;
  endfunction

  function automatic logic [LINE_W-1:0] put_beat(input logic [LINE_W-1:0] line,
                                                 input logic [BEAT_W-1:0] k,
                                                 input logic [DATA2_BUS_SIZE-1:0] d);
    logic [LINE_W-1:0] r;
    r = line;
    for (int i = 0; i < BEATS; i++) begin
      if (k == BEAT_W'(i)) r[i*DATA2_BUS_SIZE +: DATA2_BUS_SIZE] = d;
    end
    return r;
  endfunction

  mc_state_e                 state_r;
  logic [CNT_W-1:0]          cnt_r;
  logic [BEAT_W-1:0]         beat_r;
  logic [ADDR2_BUS_SIZE-1:0] addr_r;
  logic [LINE_W-1:0]         line_buf_r;
  logic                      op_wr_r;
  c2_e                       c2_out_r;
  logic [DATA2_BUS_SIZE-1:0] d2_out_r;
  logic                      c2_oe_r;
  logic                      d2_oe_r;

  logic [ADDR2_BUS_SIZE-1:0] arr_idx_s;
  logic                      arr_wr_en_s;
  logic [LINE_W-1:0]         arr_wr_line_s;
  logic [LINE_W-1:0]         arr_rd_line_s;

  mem_ctr_line_array #(
    .MEM_SIZE        (MEM_SIZE),
    .CACHE_LINE_SIZE (CACHE_LINE_SIZE),
    .ADDR2_BUS_SIZE  (ADDR2_BUS_SIZE)
  ) u_array (
    .CLK      (CLK),
    .m_dump   (M_DUMP),
    .line_idx (arr_idx_s),
    .wr_en    (arr_wr_en_s),
    .wr_line  (arr_wr_line_s),
    .rd_line  (arr_rd_line_s)
  );

  // RAM port steering: the line commits on the edge that samples its last beat.
  always_comb begin
    arr_idx_s     = addr_r;
    arr_wr_en_s   = 1'b0;
    arr_wr_line_s = put_beat(line_buf_r, BEAT_LAST, bus.D2_IN);
    if (state_r == ST_IDLE) begin
      arr_idx_s   = bus.A2_IN;
      arr_wr_en_s = SINGLE_BEAT && (bus.C2_IN == C2_WRITE_LINE);
    end else if (state_r == ST_WR_RECV) begin
      arr_wr_en_s = (beat_r == BEAT_LAST);
    end else begin
      arr_wr_en_s = 1'b0;
    end
  end

  // Controller FSM with line buffer, beat/delay counters and registered bus outputs.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_r    <= ST_IDLE;
      cnt_r      <= {CNT_W{1'b0}};
      beat_r     <= {BEAT_W{1'b0}};
      addr_r     <= {ADDR2_BUS_SIZE{1'b0}};
      line_buf_r <= {LINE_W{1'b0}};
      op_wr_r    <= 1'b0;
      c2_out_r   <= C2_NOP;
      d2_out_r   <= {DATA2_BUS_SIZE{1'b0}};
      c2_oe_r    <= 1'b0;
      d2_oe_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if ((bus.C2_IN == C2_READ_LINE) || (bus.C2_IN == C2_WRITE_LINE)) begin
            addr_r   <= bus.A2_IN;
            cnt_r    <= CNT_ONE;
            c2_oe_r  <= 1'b1;
            c2_out_r <= C2_NOP;
            op_wr_r  <= (bus.C2_IN == C2_WRITE_LINE);
            if (bus.C2_IN == C2_WRITE_LINE) begin
              line_buf_r <= put_beat(line_buf_r, BEAT_ZERO, bus.D2_IN);
              beat_r     <= BEAT_ONE;
              state_r    <= SINGLE_BEAT ? ST_WAIT : ST_WR_RECV;
            end else begin
              state_r <= ST_RD_LOAD;
            end
          end
        end
        ST_WR_RECV: begin
          line_buf_r <= put_beat(line_buf_r, beat_r, bus.D2_IN);
          beat_r     <= beat_r + 1'b1;
          cnt_r      <= cnt_r + 1'b1;
          if (beat_r == BEAT_LAST) state_r <= ST_WAIT;
        end
        ST_RD_LOAD: begin
          line_buf_r <= arr_rd_line_s;
          cnt_r      <= cnt_r + 1'b1;
          // Only reachable with the shortest legal delay on single-beat lines.
          if (cnt_r == CNT_RESP) begin
            c2_out_r <= C2_RESPONSE;
            d2_oe_r  <= 1'b1;
            d2_out_r <= get_beat(arr_rd_line_s, BEAT_ZERO);
            beat_r   <= BEAT_ONE;
            state_r  <= ST_RD_SEND;
          end else begin
            state_r <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt_r <= cnt_r + 1'b1;
          if (cnt_r == CNT_RESP) begin
            c2_out_r <= C2_RESPONSE;
            if (op_wr_r) begin
              state_r <= ST_RESP;
            end else begin
              d2_oe_r  <= 1'b1;
              d2_out_r <= get_beat(line_buf_r, BEAT_ZERO);
              beat_r   <= BEAT_ONE;
              state_r  <= ST_RD_SEND;
            end
          end
        end
        ST_RESP: begin
          c2_oe_r  <= 1'b0;
          c2_out_r <= C2_NOP;
          state_r  <= ST_IDLE;
        end
        ST_RD_SEND: begin
          if (beat_r == BEAT_END) begin
            c2_oe_r  <= 1'b0;
            d2_oe_r  <= 1'b0;
            c2_out_r <= C2_NOP;
            d2_out_r <= {DATA2_BUS_SIZE{1'b0}};
            state_r  <= ST_IDLE;
          end else begin
            d2_out_r <= get_beat(line_buf_r, beat_r);
            beat_r   <= beat_r + 1'b1;
          end
        end
        default: begin
          c2_oe_r  <= 1'b0;
          d2_oe_r  <= 1'b0;
          c2_out_r <= C2_NOP;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.C2_OUT = c2_out_r;
  assign bus.D2_OUT = d2_out_r;
  assign bus.C2_OE  = c2_oe_r;
  assign bus.D2_OE  = d2_oe_r;

endmodule

// File: tb/tb_mem_ctr_line.sv
// Scoreboard bench for mem_ctr_line: commands push expected responses, a negedge
// monitor pops them when the controller answers and checks timing, enables and data.
module tb_mem_ctr_line;
  import mem_ctr_line_pkg::*;

  localparam int MEM_SIZE = 65536;
  localparam int LINE     = 16;
  localparam int A2W      = 15;
  localparam int D2W      = 16;
  localparam int DELAY    = 12;
  localparam int BEATS    = LINE * 8 / D2W;
  localparam int LINES    = MEM_SIZE / LINE;

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  logic M_DUMP = 1'b0;

  always #5 CLK = ~CLK;

  mem_ctr_line_if #(.ADDR2_BUS_SIZE(A2W), .DATA2_BUS_SIZE(D2W)) bus ();

  mem_ctr_line #(
    .MEM_SIZE        (MEM_SIZE),
    .CACHE_LINE_SIZE (LINE),
    .ADDR2_BUS_SIZE  (A2W),
    .DATA2_BUS_SIZE  (D2W),
    .MEM_CTR_DELAY   (DELAY)
  ) dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .M_DUMP (M_DUMP),
    .bus    (bus)
  );

  typedef struct {
    bit           is_rd;
    int           t;
    logic [127:0] line;
  } txn_t;

  txn_t         sb_q[$];
  logic [127:0] model[int];
  int           checks_cnt = 0;
  int           errors_cnt = 0;
  int           edge_cnt = 0;
  bit           mon_active = 1'b0;
  bit           mon_release_chk = 1'b0;
  int           mon_beat = 0;
  txn_t         cur;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge CLK) edge_cnt <= edge_cnt + 1;

  // Monitor: 'now' is the edge number at which the current output values are sampled.
  always @(negedge CLK) begin
    int now;
    now = edge_cnt + 1;
    if (!RESET) begin
      mon_active      = 1'b0;
      mon_release_chk = 1'b0;
      sb_q.delete();
    end else begin
      if (mon_release_chk) begin
        check_val("release_c2_oe", 32'(bus.C2_OE), 32'd0);
        check_val("release_d2_oe", 32'(bus.D2_OE), 32'd0);
        check_val("release_c2_out", 32'(bus.C2_OUT), 32'(C2_NOP));
        mon_release_chk = 1'b0;
      end
      if (bus.C2_OUT == C2_RESPONSE) begin
        if (!mon_active) begin
          if (sb_q.size() == 0) begin
            check_val("unexpected_resp", 32'd1, 32'd0);
          end else begin
            cur        = sb_q.pop_front();
            mon_active = 1'b1;
            mon_beat   = 0;
            check_val("resp_latency", 32'(now - cur.t), 32'(DELAY));
          end
        end
        if (mon_active) begin
          check_val("resp_c2_oe", 32'(bus.C2_OE), 32'd1);
          if (cur.is_rd) begin
            check_val("rd_d2_oe", 32'(bus.D2_OE), 32'd1);
            check_val("rd_beat", 32'(bus.D2_OUT), 32'(cur.line[mon_beat*16 +: 16]));
          end else begin
            check_val("wr_d2_oe", 32'(bus.D2_OE), 32'd0);
          end
          mon_beat++;
          if (!cur.is_rd || mon_beat == BEATS) begin
            mon_active      = 1'b0;
            mon_release_chk = 1'b1;
          end
        end
      end else begin
        if (mon_active) begin
          check_val("resp_short", 32'(mon_beat), 32'(BEATS));
          mon_active = 1'b0;
        end
        check_val("idle_d2_oe", 32'(bus.D2_OE), 32'd0);
      end
    end
  end

  function automatic logic [127:0] expect_line(input int line);
    if (line < LINES && model.exists(line)) return model[line];
    return 128'd0;
  endfunction

  function automatic logic [127:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called at a negedge: drives the command (sampled at edge t) and any write beats.
  task automatic issue(input bit is_rd, input int line, input logic [127:0] data, output int t);
    txn_t x;
    t = edge_cnt + 1;
    bus.A2_IN = A2W'(line);
    bus.C2_IN = is_rd ? C2_READ_LINE : C2_WRITE_LINE;
    bus.D2_IN = data[15:0];
    x.is_rd = is_rd;
    x.t     = t;
    x.line  = is_rd ? expect_line(line) : 128'd0;
    sb_q.push_back(x);
    if (!is_rd && line < LINES) model[line] = data;
    for (int k = 1; k < (is_rd ? 2 : BEATS); k++) begin
      @(negedge CLK);
      if (k == 1) check_val("c2_oe_after_cmd", 32'(bus.C2_OE), 32'd1);
      bus.C2_IN = C2_NOP;
      bus.D2_IN = data[k*16 +: 16];
    end
  endtask

  task automatic wait_until(input int cyc);
    while (edge_cnt + 1 < cyc) @(negedge CLK);
  endtask

  task automatic do_write(input int line, input logic [127:0] data);
    int t;
    issue(1'b0, line, data, t);
    wait_until(t + DELAY + 1);
  endtask

  task automatic do_read(input int line);
    int t;
    issue(1'b1, line, 128'd0, t);
    wait_until(t + DELAY + BEATS);
  endtask

  initial begin
    int t;
    int ln;
    logic [127:0] d3;
    logic [127:0] dtop;

    bus.A2_IN = '0;
    bus.C2_IN = C2_NOP;
    bus.D2_IN = '0;
    repeat (3) @(negedge CLK);
    check_val("rst_c2_oe", 32'(bus.C2_OE), 32'd0);
    check_val("rst_d2_oe", 32'(bus.D2_OE), 32'd0);
    check_val("rst_c2_out", 32'(bus.C2_OUT), 32'(C2_NOP));
    check_val("rst_d2_out", 32'(bus.D2_OUT), 32'd0);
    RESET = 1'b1;
    @(negedge CLK);

    // Abort a read in its wait phase with an asynchronous reset.
    issue(1'b1, 5, 128'd0, t);
    wait_until(t + 6);
    check_val("busy_c2_oe", 32'(bus.C2_OE), 32'd1);
    #2 RESET = 1'b0;
    #1;
    check_val("abort_c2_oe", 32'(bus.C2_OE), 32'd0);
    check_val("abort_d2_oe", 32'(bus.D2_OE), 32'd0);
    check_val("abort_c2_out", 32'(bus.C2_OUT), 32'(C2_NOP));
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    do_read(5);

    // Write line 3 with ascending bytes, then read it back.
    for (int k = 0; k < BEATS; k++) d3[k*16 +: 16] = {8'(2*k + 1), 8'(2*k)};
    do_write(3, d3);

    // Read with a write command injected while busy; the write must be ignored.
    issue(1'b1, 3, 128'd0, t);
    wait_until(t + 5);
    bus.C2_IN = C2_WRITE_LINE;
    bus.A2_IN = A2W'(3);
    bus.D2_IN = 16'hDEAD;
    repeat (BEATS - 1) begin
      @(negedge CLK);
      bus.C2_IN = C2_NOP;
      bus.D2_IN = 16'hBEEF;
    end
    wait_until(t + DELAY + BEATS);

    // Write with a read command injected while busy.
    issue(1'b0, 7, rand_line(), t);
    wait_until(t + 9);
    bus.C2_IN = C2_READ_LINE;
    bus.A2_IN = A2W'(3);
    @(negedge CLK);
    bus.C2_IN = C2_NOP;
    wait_until(t + DELAY + 1);
    do_read(3);
    do_read(7);

    // Out-of-range line must not alias onto the top in-range line.
    dtop = rand_line();
    do_write(LINES - 1, dtop);
    do_write(15'h7FFF, rand_line());
    do_read(15'h7FFF);
    do_read(LINES - 1);

    // Back-to-back: read issued on the first idle cycle after the write releases.
    do_write(1, rand_line());
    do_read(1);

    for (int i = 0; i < 6; i++) begin
      ln = int'($urandom_range(0, 63));
      do_write(ln, rand_line());
      do_read(ln);
      do_read(int'($urandom_range(0, 63)));
    end

    repeat (5) @(negedge CLK);
    check_val("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
